mem_port_arbiter: RTL and testbench

//  Shares the single-port Memory between instruction fetch (IF) and data (DM) requesters.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data requesters; one access in flight, all outputs registered.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    state_t          state;
    owner_t          owner;
    owner_t          last;
    owner_t          pick;
    logic            acc_we;
    logic [CW-1:0]   cnt;

    // Winner for the next IDLE edge; a tie goes to whoever was not served last.
    always_comb begin
        pick = OWN_IF;
        if (if_req && dm_req)
            pick = (last == OWN_IF) ? OWN_DM : OWN_IF;
        else if (dm_req)
            pick = OWN_DM;
    end

    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            last      <= OWN_DM;
            acc_we    <= 1'b0;
            cnt       <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_gnt    <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            busy      <= 1'b0;
        end else begin
            // Grants and valids are single-cycle pulses unless re-raised below.
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        state <= ACCESS;
                        owner <= pick;
                        last  <= pick;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        if (pick == OWN_IF) begin
                            if_gnt   <= 1'b1;
                            acc_we   <= 1'b0;
                            mem_addr <= if_addr;
                            mem_ren  <= 1'b1;
                            mem_wen  <= 1'b0;
                        end else begin
                            dm_gnt   <= 1'b1;
                            acc_we   <= dm_we;
                            mem_addr <= dm_addr;
                            mem_din  <= dm_wdata;
                            mem_ren  <= ~dm_we;
                            mem_wen  <= dm_we;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state   <= DONE;
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                        if (owner == OWN_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_dout;
                        end else begin
                            dm_rvalid <= 1'b1;
                            if (!acc_we)
                                dm_rdata <= mem_dout;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-timeline model checks the
// WAIT_CYCLES=1 instance every cycle; directed literals pin both instances.
module tb_mem_port_arbiter;

    localparam int W1 = 1;
    localparam int W3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- instance with WAIT_CYCLES=1 ----------------
    logic        reset1 = 1'b1;
    logic        if_req1 = 1'b0, dm_req1 = 1'b0, dm_we1 = 1'b0;
    logic [31:0] if_addr1 = '0, dm_addr1 = '0, dm_wdata1 = '0;
    logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_ren1, mem_wen1, busy1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_din1, mem_dout1;
    logic [31:0] mem1 [256];

    assign mem_dout1 = mem1[mem_addr1[7:0]];

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W1)) dut1 (
        .clock(clk), .reset(reset1),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
        .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
        .mem_ren(mem_ren1), .mem_wen(mem_wen1), .mem_addr(mem_addr1),
        .mem_din(mem_din1), .mem_dout(mem_dout1), .busy(busy1)
    );

    // ---------------- instance with WAIT_CYCLES=3 ----------------
    logic        reset3 = 1'b1;
    logic        if_req3 = 1'b0, dm_req3 = 1'b0, dm_we3 = 1'b0;
    logic [31:0] if_addr3 = '0, dm_addr3 = '0, dm_wdata3 = '0;
    logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_ren3, mem_wen3, busy3;
    logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_din3, mem_dout3;
    logic [31:0] mem3 [256];

    assign mem_dout3 = mem3[mem_addr3[7:0]];

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W3)) dut3 (
        .clock(clk), .reset(reset3),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
        .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
        .mem_ren(mem_ren3), .mem_wen(mem_wen3), .mem_addr(mem_addr3),
        .mem_din(mem_din3), .mem_dout(mem_dout3), .busy(busy3)
    );

    // Memory contents and write port for both instances (only dut1 ever writes).
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'hA500_0000 | i;
            mem3[i] = 32'h5A00_0000 | i;
        end
        mem1[8'h10] = 32'hCAFE_0001;
        mem3[8'h30] = 32'hBEEF_0003;
        forever begin
            @(posedge clk);
            if (mem_wen1)
                mem1[mem_addr1[7:0]] = mem_din1;
        end
    end

    // Transaction-timeline model of dut1: a request accepted at edge g owns the
    // strobes after edges g..g+W-1, reports after edge g+W, and the next request
    // can only be sampled at edge g+W+2.
    initial begin
        int          cyc, g, next_sample;
        bit          tv, t_dm, t_we, last_dm, dm_wins;
        bit          acc, don, gn;
        logic [31:0] t_addr, t_wd, e_if_rd, e_dm_rd;
        logic [31:0] ref_mem [256];
        for (int i = 0; i < 256; i++)
            ref_mem[i] = 32'hA500_0000 | i;
        ref_mem[8'h10] = 32'hCAFE_0001;
        cyc = 0; g = 0; next_sample = 0; tv = 0; t_dm = 0; t_we = 0; last_dm = 1;
        t_addr = '0; t_wd = '0; e_if_rd = '0; e_dm_rd = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset1) begin
                tv = 0; next_sample = cyc + 1; last_dm = 1;
                e_if_rd = '0; e_dm_rd = '0;
            end else begin
                if (tv && cyc == g + W1 && !t_we) begin
                    if (t_dm) e_dm_rd = ref_mem[t_addr[7:0]];
                    else      e_if_rd = ref_mem[t_addr[7:0]];
                end
                if (cyc == next_sample) begin
                    if (if_req1 || dm_req1) begin
                        dm_wins = (if_req1 && dm_req1) ? !last_dm : dm_req1;
                        tv      = 1;
                        g       = cyc;
                        t_dm    = dm_wins;
                        t_we    = dm_wins && dm_we1;
                        t_addr  = dm_wins ? dm_addr1 : if_addr1;
                        t_wd    = dm_wdata1;
                        last_dm = dm_wins;
                        if (t_we) ref_mem[t_addr[7:0]] = t_wd;
                        next_sample = cyc + W1 + 2;
                    end else begin
                        next_sample = cyc + 1;
                    end
                end
            end
            #1;
            gn  = tv && cyc == g;
            acc = tv && cyc >= g && cyc <= g + W1 - 1;
            don = tv && cyc == g + W1;
            check("m_if_gnt",    if_gnt1,    gn && !t_dm);
            check("m_dm_gnt",    dm_gnt1,    gn && t_dm);
            check("m_mem_ren",   mem_ren1,   acc && !t_we);
            check("m_mem_wen",   mem_wen1,   acc && t_we);
            check("m_if_rvalid", if_rvalid1, don && !t_dm);
            check("m_dm_rvalid", dm_rvalid1, don && t_dm);
            check("m_busy",      busy1,      acc || don);
            check("m_if_rdata",  if_rdata1,  e_if_rd);
            check("m_dm_rdata",  dm_rdata1,  e_dm_rd);
            if (acc) check("m_mem_addr", mem_addr1, t_addr);
            if (acc && t_we) check("m_mem_din", mem_din1, t_wd);
        end
    end

    task automatic if_read(input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk); if_req1 = 1'b1; if_addr1 = a;
        @(posedge clk); #1;
        check("if_gnt",    if_gnt1,   1);
        check("if_ren",    mem_ren1,  1);
        check("if_wen",    mem_wen1,  0);
        check("if_addr",   mem_addr1, a);
        @(negedge clk); if_req1 = 1'b0;
        @(posedge clk); #1;
        check("if_rvalid", if_rvalid1, 1);
        check("if_rdata",  if_rdata1,  exp);
        check("if_ren_off", mem_ren1,  0);
        @(posedge clk);
    endtask

    task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd);
        @(negedge clk); dm_req1 = 1'b1; dm_we1 = we; dm_addr1 = a; dm_wdata1 = wd;
        @(posedge clk); #1;
        check("dm_gnt",  dm_gnt1,   1);
        check("dm_ren",  mem_ren1,  !we);
        check("dm_wen",  mem_wen1,  we);
        check("dm_addr", mem_addr1, a);
        if (we) check("dm_din", mem_din1, wd);
        @(negedge clk); dm_req1 = 1'b0;
        @(posedge clk); #1;
        check("dm_rvalid",  dm_rvalid1, 1);
        check("dm_rdata",   dm_rdata1,  exp_rd);
        check("dm_wen_off", mem_wen1,   0);
        @(posedge clk);
    endtask

    initial begin
        // Reset held two cycles with both requests raised.
        if_req1 = 1'b1; dm_req1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_if_gnt", if_gnt1,  0);
            check("rst_dm_gnt", dm_gnt1,  0);
            check("rst_ren",    mem_ren1, 0);
            check("rst_wen",    mem_wen1, 0);
            check("rst_busy",   busy1,    0);
        end
        @(negedge clk);
        reset1 = 1'b0; reset3 = 1'b0; if_req1 = 1'b0; dm_req1 = 1'b0;
        @(posedge clk);

        // Single IF read, then DM write and read-back.
        if_read(32'h10, 32'hCAFE_0001);
        dm_access(1'b1, 32'h20, 32'h1234_5678, 32'h0);
        dm_access(1'b0, 32'h20, 32'h0, 32'h1234_5678);

        // Both requesters held from reset: IF, DM, IF, DM every third cycle.
        @(negedge clk);
        reset1 = 1'b1; if_req1 = 1'b1; if_addr1 = 32'h10;
        dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 32'h20;
        @(posedge clk);
        @(negedge clk); reset1 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            check("rr_if_gnt", if_gnt1, (i == 1 || i == 7));
            check("rr_dm_gnt", dm_gnt1, (i == 4 || i == 10));
        end
        @(negedge clk); if_req1 = 1'b0; dm_req1 = 1'b0;

        // Reset during the ACCESS phase of a DM read.
        @(negedge clk); dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 32'h20;
        @(posedge clk); #1;
        check("ra_dm_gnt", dm_gnt1, 1);
        @(negedge clk); reset1 = 1'b1; dm_req1 = 1'b0;
        @(posedge clk); #1;
        check("ra_rvalid", dm_rvalid1, 0);
        check("ra_ren",    mem_ren1,   0);
        check("ra_busy",   busy1,      0);
        check("ra_rdata",  dm_rdata1,  0);
        @(negedge clk); reset1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("ra_no_rvalid", dm_rvalid1, 0);
        end
        if_read(32'h10, 32'hCAFE_0001);

        // WAIT_CYCLES=3 DM read: strobe three cycles, rvalid on the fourth.
        @(negedge clk); dm_req3 = 1'b1; dm_we3 = 1'b0; dm_addr3 = 32'h30;
        @(posedge clk); #1;
        check("w3_gnt",   dm_gnt3,   1);
        check("w3_ren0",  mem_ren3,  1);
        check("w3_wen0",  mem_wen3,  0);
        check("w3_addr0", mem_addr3, 32'h30);
        check("w3_din",   mem_din3,  0);
        check("w3_busy0", busy3,     1);
        check("w3_ifgnt", if_gnt3,   0);
        @(negedge clk); dm_req3 = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            @(posedge clk); #1;
            check("w3_gnt_off", dm_gnt3,    0);
            check("w3_ren",     mem_ren3,   1);
            check("w3_wen",     mem_wen3,   0);
            check("w3_addr",    mem_addr3,  32'h30);
            check("w3_early",   dm_rvalid3, 0);
        end
        @(posedge clk); #1;
        check("w3_ren_off", mem_ren3,   0);
        check("w3_rvalid",  dm_rvalid3, 1);
        check("w3_rdata",   dm_rdata3,  32'hBEEF_0003);
        check("w3_busy3",   busy3,      1);
        check("w3_if_rv",   if_rvalid3, 0);
        @(posedge clk); #1;
        check("w3_idle",    busy3,      0);
        check("w3_rv_off",  dm_rvalid3, 0);
        check("w3_if_rd",   if_rdata3,  0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
